grass_round_ctrl: RTL and testbench

//  Iterative Grasshopper (GOST R 34.12-2015, Kuznyechik) 128-bit block encryption controller.

---
 rtl/grass_pkg.sv | 39 +++
 rtl/grass_r_step.sv | 20 ++
 rtl/linear.sv | 35 +++
 rtl/grass_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_grass_round_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grass_pkg.sv
// Grasshopper (Kuznyechik) shared constants, FSM encoding and GF(2^8) multiply.
package grass_pkg;

   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned NBYTES  = BLOCK_W / BYTE_W;
   localparam int unsigned STEP_W  = 4;

   // Low byte of the field modulus x^8+x^7+x^6+x+1
   localparam logic [BYTE_W-1:0] GF_POLY = 8'hC3;

   // Coefficients of l(), ordered a15 first down to a0
   localparam logic [BYTE_W-1:0] L_COEF [0:NBYTES-1] = '{
      8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
   };

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SUBX  = 3'd1,
      ST_LIN   = 3'd2,
      ST_FINAL = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] acc;
      logic [BYTE_W-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < int'(BYTE_W); i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[BYTE_W-2:0], 1'b0} ^ (sh[BYTE_W-1] ? GF_POLY : '0);
      end
      return acc;
   endfunction

endpackage

// File: rtl/grass_r_step.sv
// One Grasshopper R-step: R(a) = {l(a), a[127:8]}, pure combinational.
module grass_r_step
   import grass_pkg::*;
(
   input  logic [BLOCK_W-1:0] a_i,
   output logic [BLOCK_W-1:0] r_c
);

   logic [BYTE_W-1:0] l_c;

   always_comb begin
      l_c = '0;
      for (int i = 0; i < int'(NBYTES); i++) begin
         l_c = l_c ^ gf_mul(L_COEF[i], a_i[(int'(NBYTES) - 1 - i)*BYTE_W +: BYTE_W]);
      end
   end

   assign r_c = {l_c, a_i[BLOCK_W-1:BYTE_W]};

endmodule

// File: rtl/linear.sv
// Grasshopper S-layer: byte-wise pi substitution over the 128-bit block.
module linear
   import grass_pkg::*;
(
   input  logic [BLOCK_W-1:0] din_i,
   output logic [BLOCK_W-1:0] dout_c
);

   localparam logic [7:0] PI [0:255] = '{
      8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
      8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
      8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
      8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
      8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
      8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
      8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
      8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
      8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
      8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
      8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
      8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
      8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
      8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
      8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
      8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
   };

   always_comb begin
      dout_c = '0;
      for (int i = 0; i < int'(NBYTES); i++) begin
         dout_c[i*BYTE_W +: BYTE_W] = PI[din_i[i*BYTE_W +: BYTE_W]];
      end
   end

endmodule

// File: rtl/grass_round_ctrl.sv
// Iterative Grasshopper encryption round controller (X-S-L rounds, final X).
// GRASS_L_PARALLEL_EN: full 16-step L in one cycle instead of one R-step per clock.
module grass_round_ctrl
   import grass_pkg::*;
#(
   parameter int unsigned FULL_ROUNDS = 9,
   parameter int unsigned KIDX_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [BLOCK_W-1:0] data_i,
   output logic [KIDX_W-1:0]  key_idx_o,
   input  logic [BLOCK_W-1:0] key_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [BLOCK_W-1:0] data_o,
   output logic               busy_o
);

   state_e             state_q, state_d;
   logic [BLOCK_W-1:0] st_q, st_d;
   logic [KIDX_W-1:0]  round_q, round_d;
   logic [KIDX_W-1:0]  kidx_q, kidx_d;
   logic               ready_q, ready_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic [BLOCK_W-1:0] sbox_c;
   logic [BLOCK_W-1:0] lin_c;
   logic               last_step_c;

   linear u_slayer (
      .din_i  (st_q ^ key_i),
      .dout_c (sbox_c)
   );

`ifdef GRASS_L_PARALLEL_EN
   logic [BLOCK_W-1:0] chain_c [0:NBYTES];

   assign chain_c[0] = st_q;
   for (genvar g = 0; g < int'(NBYTES); g++) begin : g_lchain
      grass_r_step u_r_step (
         .a_i (chain_c[g]),
         .r_c (chain_c[g+1])
      );
   end
   assign lin_c       = chain_c[NBYTES];
   assign last_step_c = 1'b1;
`else
   logic [STEP_W-1:0] step_q, step_d;

   grass_r_step u_r_step (
      .a_i (st_q),
      .r_c (lin_c)
   );
   assign last_step_c = (step_q == STEP_W'(NBYTES - 1));
`endif

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      round_d = round_q;
      kidx_d  = kidx_q;
`ifndef GRASS_L_PARALLEL_EN
      step_d  = step_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               st_d    = data_i;
               round_d = '0;
               kidx_d  = '0;
               state_d = ST_SUBX;
            end
         end
         ST_SUBX: begin
            st_d    = sbox_c;
`ifndef GRASS_L_PARALLEL_EN
            step_d  = '0;
`endif
            state_d = ST_LIN;
         end
         ST_LIN: begin
            st_d = lin_c;
`ifndef GRASS_L_PARALLEL_EN
            step_d = step_q + STEP_W'(1);
`endif
            if (last_step_c) begin
               round_d = round_q + KIDX_W'(1);
               if (round_q < KIDX_W'(FULL_ROUNDS - 1)) begin
                  kidx_d  = round_q + KIDX_W'(1);
                  state_d = ST_SUBX;
               end else begin
                  kidx_d  = KIDX_W'(FULL_ROUNDS);
                  state_d = ST_FINAL;
               end
            end
         end
         ST_FINAL: begin
            st_d    = st_q ^ key_i;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
      valid_d = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         st_q    <= '0;
         round_q <= '0;
         kidx_q  <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
`ifndef GRASS_L_PARALLEL_EN
         step_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         round_q <= round_d;
         kidx_q  <= kidx_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
`ifndef GRASS_L_PARALLEL_EN
         step_q  <= step_d;
`endif
      end
   end

   assign ready_o   = ready_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy_q;
   assign key_idx_o = kidx_q;
   assign data_o    = st_q;

endmodule

// File: tb/tb_grass_round_ctrl.sv
// Directed bench for grass_round_ctrl with an independent Kuznyechik model and
// a ciphertext scoreboard; follows GRASS_L_PARALLEL_EN for the expected timing.
module tb_grass_round_ctrl;

   localparam int FULL_ROUNDS = 9;
`ifdef GRASS_L_PARALLEL_EN
   localparam int LIN_CYC = 1;
`else
   localparam int LIN_CYC = 16;
`endif
   localparam int RC  = LIN_CYC + 1;
   localparam int LAT = FULL_ROUNDS * RC + 1;

   localparam logic [127:0] GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;
   localparam logic [127:0] GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
   localparam logic [127:0] S_INV_V = 128'hacba95a5a5a5a5a5a5a5a5a5a5a5a5a5;
   localparam logic [127:0] S_OUT_V = 128'h64a59400000000000000000000000000;
   localparam logic [127:0] L_OUT_V = 128'hd456584dd0e3e84cc3166e4b7fa2890d;

   localparam logic [7:0] M_PI [0:255] = '{
      8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
      8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
      8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
      8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
      8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
      8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
      8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
      8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
      8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
      8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
      8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
      8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
      8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
      8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
      8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
      8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
   };

   localparam logic [7:0] M_LC [0:15] = '{
      8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_i;
   logic         ready_o;
   logic [127:0] data_i;
   logic [3:0]   key_idx_o;
   logic [127:0] key_i;
   logic         valid_o;
   logic         ready_i;
   logic [127:0] data_o;
   logic         busy_o;
   logic [127:0] rs_a;
   logic [127:0] rs_r;

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           acc_cyc = 0;
   logic [127:0] sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Round keys K1..K10 of the GOST reference key, indexed by key_idx_o
   function automatic logic [127:0] rk_of(input logic [3:0] idx);
      case (idx)
         4'd0:    return 128'h8899aabbccddeeff0011223344556677;
         4'd1:    return 128'hfedcba98765432100123456789abcdef;
         4'd2:    return 128'hdb31485315694343228d6aef8cc78c44;
         4'd3:    return 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
         4'd4:    return 128'h57646468c44a5e28d3e59246f429f1ac;
         4'd5:    return 128'hbd079435165c6432b532e82834da581b;
         4'd6:    return 128'h51e640757e8745de705727265a0098b1;
         4'd7:    return 128'h5a7925017b9fdd3ed72a91a22286f984;
         4'd8:    return 128'hbb44e25378c73123a5f32f73cdb6e517;
         4'd9:    return 128'h72e9dd7416bcf45b755dbaa88e4a4043;
         default: return '0;
      endcase
   endfunction

   assign key_i = rk_of(key_idx_o);

   grass_round_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .data_i    (data_i),
      .key_idx_o (key_idx_o),
      .key_i     (key_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .data_o    (data_o),
      .busy_o    (busy_o)
   );

   grass_r_step u_rs (
      .a_i (rs_a),
      .r_c (rs_r)
   );

   // Carry-less product followed by reduction modulo 0x1C3
   function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h01C3 << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] m_r(input logic [127:0] a);
      logic [7:0] l;
      l = '0;
      for (int i = 0; i < 16; i++) l = l ^ m_gmul(M_LC[i], a[8*(15-i) +: 8]);
      return {l, a[127:8]};
   endfunction

   function automatic logic [127:0] m_enc(input logic [127:0] pt);
      logic [127:0] s;
      s = pt;
      for (int r = 0; r < FULL_ROUNDS; r++) begin
         s = s ^ rk_of(4'(r));
         for (int b = 0; b < 16; b++) s[8*b +: 8] = M_PI[s[8*b +: 8]];
         for (int k = 0; k < 16; k++) s = m_r(s);
      end
      return s ^ rk_of(4'(FULL_ROUNDS));
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 128'(ready_o), 128'd1);
      chk({tag, "_valid"}, 128'(valid_o), 128'd0);
      chk({tag, "_busy"}, 128'(busy_o), 128'd0);
      chk({tag, "_kidx"}, 128'(key_idx_o), 128'd0);
      chk({tag, "_data"}, data_o, 128'd0);
   endtask

   // Present a block in IDLE and let it be accepted on the next edge
   task automatic send(input logic [127:0] pt, input logic [127:0] exp, input bit hold);
      valid_i = 1'b1;
      data_i  = pt;
      sb.push_back(exp);
      chk("ready_before_accept", 128'(ready_o), 128'd1);
      @(posedge clk); #1;
      if (!hold) valid_i = 1'b0;
      acc_cyc = cyc;
      chk("busy_after_accept", 128'(busy_o), 128'd1);
      chk("ready_after_accept", 128'(ready_o), 128'd0);
   endtask

   // Follow the block to valid_o, checking key index schedule, latency and ciphertext
   task automatic collect(input bit mid);
      int           n;
      logic [127:0] exp;
      n = 0;
      while (valid_o !== 1'b1 && n < LAT + 20) begin
         if ((n % RC) == 0 && (n / RC) <= FULL_ROUNDS)
            chk("key_idx", 128'(key_idx_o), 128'(n / RC));
         if (mid && n == 1) chk("s_layer_state", data_o, S_OUT_V);
         if (mid && n == RC) chk("l_transform_state", data_o, L_OUT_V);
         if (n == LAT / 2) begin
            chk("busy_mid_block", 128'(busy_o), 128'd1);
            chk("ready_mid_block", 128'(ready_o), 128'd0);
         end
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 128'(n), 128'(LAT));
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("ciphertext", data_o, exp);
   endtask

   task automatic handshake();
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      chk("hs_ready", 128'(ready_o), 128'd1);
      chk("hs_valid", 128'(valid_o), 128'd0);
      chk("hs_busy", 128'(busy_o), 128'd0);
   endtask

   initial begin
      logic [127:0] p;
      logic [127:0] held;
      int           prev_acc;
      int           n_rst;

      rst     = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      rs_a    = '0;
      #1 rst = 1'b1;
      #11;
      chk_reset_vals("reset");

      // Standalone R-step: reference vector and model comparisons
      rs_a = 128'h00000000000000000000000000000100;
      #1 chk("rstep_vec", rs_r, 128'h94000000000000000000000000000001);
      for (int i = 0; i < 3; i++) begin
         rs_a = rnd128();
         #1 chk("rstep_rand", rs_r, m_r(rs_a));
      end

      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset_vals("idle_after_reset");

      // First round lands S and L reference vectors in the state register
      p = S_INV_V ^ rk_of(4'd0);
      send(p, m_enc(p), 1'b0);
      collect(1'b1);
      handshake();

      // GOST reference vector
      send(GOST_PT, GOST_CT, 1'b0);
      collect(1'b0);
      handshake();

      // Random block followed by 20 cycles of backpressure with valid_i asserted
      p = rnd128();
      send(p, m_enc(p), 1'b0);
      collect(1'b0);
      held    = m_enc(p);
      valid_i = 1'b1;
      data_i  = rnd128();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", 128'(valid_o), 128'd1);
         chk("bp_data", data_o, held);
         chk("bp_ready", 128'(ready_o), 128'd0);
      end
      valid_i = 1'b0;
      handshake();

      // Reset in round 4 mid-L, then a clean block
      p = rnd128();
      send(p, m_enc(p), 1'b0);
      n_rst = 4 * RC + 1 + ((LIN_CYC > 7) ? 7 : 0);
      repeat (n_rst) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("midblock_reset");
      sb.delete();
      @(posedge clk); #1;
      chk_reset_vals("reset_held");
      rst = 1'b0;
      @(posedge clk); #1;
      send(GOST_PT, GOST_CT, 1'b0);
      collect(1'b0);
      handshake();

      // Back-to-back stream with valid_i and ready_i held high
      ready_i = 1'b1;
      p = rnd128();
      send(p, m_enc(p), 1'b1);
      prev_acc = acc_cyc;
      for (int b = 0; b < 2; b++) begin
         collect(1'b0);
         p = rnd128();
         data_i = p;
         sb.push_back(m_enc(p));
         @(posedge clk); #1;
         chk("b2b_ready_after_hs", 128'(ready_o), 128'd1);
         chk("b2b_valid_after_hs", 128'(valid_o), 128'd0);
         @(posedge clk); #1;
         chk("b2b_busy", 128'(busy_o), 128'd1);
         chk("b2b_interval", 128'(cyc - prev_acc), 128'(LAT + 2));
         prev_acc = cyc;
      end
      collect(1'b0);
      valid_i = 1'b0;
      @(posedge clk); #1;
      ready_i = 1'b0;
      chk("final_ready", 128'(ready_o), 128'd1);
      chk("final_busy", 128'(busy_o), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
